int_pixel_packer: RTL
=====================

Name: int_pixel_packer

Overview:
- Downstream stage of the posit-to-integer converter in the vision pipe.
- Accepts one 8-bit unsigned pixel per beat (converter output, already clamped 0..255) over a valid/ready handshake.
- Packs PACK pixels into one 32-bit word, little-endian (first pixel in bits 7:0).
- Buffers packed words in a small FIFO and presents them to the memory/stream interface with its own valid/ready handshake.
- A row-end marker flushes a partial word with a byte-keep mask.

Parameters:
- PIX_W, 8, pixel width in bits; must match the converter integer width.
- PACK, 4, pixels per output word; output width is PIX_W*PACK.
- FIFO_DEPTH, 4, words of output buffering; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_pix  input  PIX_W  pixel from the converter.
- in_valid  input  1  in_pix is valid.
- in_last  input  1  last pixel of a row; qualified by in_valid.
- in_ready  output  1  packer can accept a beat.
- out_word  output  PIX_W*PACK  packed word at the FIFO head.
- out_keep  output  PACK  per-pixel valid mask; bit i covers byte lane i.
- out_last  output  1  word closes a row.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  downstream accepts the word.
- sat_hi_cnt  output  16  count of pixels equal to 255 (optional feature).
- sat_lo_cnt  output  16  count of pixels equal to 0 (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - Accumulator lane index = 0, accumulator data = 0.
  - FIFO empty, out_valid = 0, out_word = 0, out_keep = 0, out_last = 0.
  - in_ready = 1, stats counters = 0.
- Reset mid-operation discards any partial word and all FIFO contents; no flush is generated.
- Input accept: a beat is accepted when in_valid && in_ready.
  - The pixel is written to lane idx and idx increments.
  - in_ready = (fifo_count < FIFO_DEPTH). It depends only on registered state; there is no combinational path from out_ready.
- Word completion occurs on an accepted beat when idx == PACK-1 or in_last = 1.
  - The assembled word is pushed into the FIFO with:
    - keep = lanes 0..idx set;
    - unused lanes = 0;
    - last = in_last.
  - idx returns to 0 and the accumulator data clears.
- in_last with idx == PACK-1 produces one full word (keep = 4'b1111) with last = 1. No extra empty word is generated.
- Latency: a completed word is visible on out_valid the cycle after the completing beat (registered FIFO, no bypass).
- Output pop occurs when out_valid && out_ready. The head advances, and the next entry appears in the same cycle's next state.
- Simultaneous push and pop: fifo_count is unchanged and both take effect. A push while full cannot occur because in_ready is low.
- Full/empty:
  - fifo_count == FIFO_DEPTH deasserts in_ready, even if the next beat would not complete a word. This conservative stall is intentional.
  - When empty, out_valid = 0 and out_word, out_keep and out_last hold their last values (don't-care to downstream).
- Pointers: read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- Output stability: while out_valid = 1 and out_ready = 0, out_word, out_keep and out_last are held stable.
- in_last with in_valid = 0 is ignored.

Optional Feature:
- Macro: PIX_STATS_EN.
- Defined:
  - On each accepted beat, sat_hi_cnt increments if in_pix == 255 and sat_lo_cnt increments if in_pix == 0.
  - Both counters saturate at 16'hFFFF and clear on rst.
  - Counters update the cycle after acceptance.
- Undefined:
  - No counter logic is built.
  - sat_hi_cnt and sat_lo_cnt are driven constant 0.
  - Port list is unchanged.

Test Plan:
- Reset then stream pixels 0x11, 0x22, 0x33, 0x44 with out_ready = 1. Required: out_word = 32'h44332211, keep = 4'b1111, last = 0; out_valid high exactly 1 cycle, one cycle after the 4th beat.
- Pixels 0xAA, 0xBB with in_last on 0xBB. Required: out_word = 32'h0000BBAA, keep = 4'b0011, last = 1; the next pixel 0x01 lands in lane 0.
- out_ready = 0; stream 20 pixels. Required: in_ready drops after 16 pixels (4 words queued). Release out_ready: words pop in order and in_ready reasserts the cycle after the first pop; no data is lost or duplicated.
- Steady full-rate streaming with out_ready toggling every other cycle (push/pop coincident). Required: fifo_count never exceeds 4 and the word order is preserved over 64 pixels.
- Assert rst mid-word after 2 pixels with 2 words queued. Required: out_valid = 0 immediately, in_ready = 1. Subsequent pixels 0x01..0x04 yield 32'h04030201 with no residue.
- With PIX_STATS_EN: stream 0xFF, 0x00, 0xFF, 0x7F. Required: sat_hi_cnt = 2, sat_lo_cnt = 1. Without PIX_STATS_EN both read 0.

Source files
------------

// File: rtl/int_pixel_packer.sv
// Packs PACK pixels per word (little-endian) with a row-end flush and keep mask,
// buffered in a small FIFO. Define PIX_STATS_EN to build the saturation counters.
module int_pixel_packer #(
    parameter int PIX_W      = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_W-1:0]      in_pix,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [PIX_W*PACK-1:0] out_word,
    output logic [PACK-1:0]       out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           sat_hi_cnt,
    output logic [15:0]           sat_lo_cnt
);
    localparam int W  = PIX_W * PACK;
    localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0]                idx;
    logic [PACK-1:0][PIX_W-1:0]   acc;
    logic [PACK-1:0][PIX_W-1:0]   push_word;
    logic [PACK-1:0]              push_keep;
    logic                         accept, push, pop;

    logic [W-1:0]                 mem_word [FIFO_DEPTH];
    logic [PACK-1:0]              mem_keep [FIFO_DEPTH];
    logic                         mem_last [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]                count, count_next;

    // in_ready looks only at the registered count, never at out_ready
    assign in_ready  = (count < CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && ((idx == IW'(PACK - 1)) || in_last);
    assign pop       = out_valid && out_ready;

    always_comb begin
        for (int i = 0; i < PACK; i++) begin
            push_word[i] = (IW'(i) == idx) ? in_pix : acc[i];
            push_keep[i] = (IW'(i) <= idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            if (push) begin
                idx <= '0;
                acc <= '0;
            end else begin
                acc[idx] <= in_pix;
                idx      <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= push_word;
            mem_keep[wr_ptr] <= push_keep;
            mem_last[wr_ptr] <= in_last;
        end
    end

    // Output registers preload the next head; a word pushed into the slot that
    // is about to become head is forwarded since the memory write lands later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_word <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0) begin
                if (push && (wr_ptr == rd_next)) begin
                    out_word <= push_word;
                    out_keep <= push_keep;
                    out_last <= in_last;
                end else begin
                    out_word <= mem_word[rd_next];
                    out_keep <= mem_keep[rd_next];
                    out_last <= mem_last[rd_next];
                end
            end
        end
    end

`ifdef PIX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_hi_cnt <= '0;
            sat_lo_cnt <= '0;
        end else if (accept) begin
            if ((in_pix == {PIX_W{1'b1}}) && (sat_hi_cnt != 16'hFFFF)) sat_hi_cnt <= sat_hi_cnt + 16'd1;
            if ((in_pix == '0) && (sat_lo_cnt != 16'hFFFF)) sat_lo_cnt <= sat_lo_cnt + 16'd1;
        end
    end
`else
    assign sat_hi_cnt = '0;
    assign sat_lo_cnt = '0;
`endif

endmodule
